// File: rtl/victim_cache_ctrl.sv
// Victim cache sequencing controller: serves one dcache line miss at a time,
// arbitrating the shared victim cache port and the memory bus.
module victim_cache_ctrl #(
  parameter int DCACHE_LINE_WIDTH = 128,
  parameter int VICTIM_ADDR_BITS  = 28
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_i,
  input  logic                         dcache_miss_req_i,
  input  logic [VICTIM_ADDR_BITS-1:0]  dcache_miss_addr_i,
  input  logic                         dcache_evict_valid_i,
  input  logic                         dcache_evict_dirty_i,
  input  logic [VICTIM_ADDR_BITS-1:0]  dcache_evict_addr_i,
  input  logic [DCACHE_LINE_WIDTH-1:0] dcache_evict_data_i,
  output logic                         dcache_miss_ack_o,
  output logic [DCACHE_LINE_WIDTH-1:0] dcache_fill_data_o,
  output logic                         dcache_fill_src_o,
  output logic                         busy_o,
  output logic [VICTIM_ADDR_BITS-1:0]  victim_addr_o,
  output logic [DCACHE_LINE_WIDTH-1:0] victim_wr_data_o,
  output logic                         victim_wr_en_o,
  output logic                         victim_flush_o,
  input  logic                         victim_hit_i,
  input  logic [DCACHE_LINE_WIDTH-1:0] victim_rd_data_i,
  output logic                         mem_req_o,
  output logic                         mem_we_o,
  output logic [VICTIM_ADDR_BITS-1:0]  mem_addr_o,
  output logic [DCACHE_LINE_WIDTH-1:0] mem_wdata_o,
  input  logic                         mem_ack_i,
  input  logic [DCACHE_LINE_WIDTH-1:0] mem_rdata_i
);

  typedef enum logic [2:0] {IDLE, LOOKUP, WB, MEM_RD, INSERT, RESP} state_t;

  state_t                       state, state_next;
  logic [VICTIM_ADDR_BITS-1:0]  miss_addr;
  logic                         evict_valid;
  logic                         evict_dirty;
  logic [VICTIM_ADDR_BITS-1:0]  evict_addr;
  logic [DCACHE_LINE_WIDTH-1:0] evict_data;
  logic [DCACHE_LINE_WIDTH-1:0] fill_buf;
  logic                         hit_q;
  logic                         flush_pending;
  logic                         flush_fire;
  logic                         accept;

  // A miss request in IDLE wins over a pending flush; the flush waits for the next IDLE.
  assign accept     = (state == IDLE) && dcache_miss_req_i;
  assign flush_fire = (state == IDLE) && flush_pending && !dcache_miss_req_i;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      miss_addr     <= '0;
      evict_valid   <= 1'b0;
      evict_dirty   <= 1'b0;
      evict_addr    <= '0;
      evict_data    <= '0;
      fill_buf      <= '0;
      hit_q         <= 1'b0;
      flush_pending <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        miss_addr   <= dcache_miss_addr_i;
        evict_valid <= dcache_evict_valid_i;
        evict_dirty <= dcache_evict_dirty_i;
        evict_addr  <= dcache_evict_addr_i;
        evict_data  <= dcache_evict_data_i;
      end
      if (state == LOOKUP) begin
        hit_q <= victim_hit_i;
        if (victim_hit_i)
          fill_buf <= victim_rd_data_i;
      end
      if (state == MEM_RD && mem_ack_i)
        fill_buf <= mem_rdata_i;
      if (flush_i)
        flush_pending <= 1'b1;
      else if (flush_fire)
        flush_pending <= 1'b0;
    end
  end

  // Outputs decode purely from state so every idle-side bus reads as zero.
  always_comb begin
    state_next         = state;
    busy_o             = (state != IDLE);
    dcache_miss_ack_o  = 1'b0;
    dcache_fill_data_o = '0;
    dcache_fill_src_o  = 1'b0;
    victim_addr_o      = '0;
    victim_wr_data_o   = '0;
    victim_wr_en_o     = 1'b0;
    victim_flush_o     = flush_fire;
    mem_req_o          = 1'b0;
    mem_we_o           = 1'b0;
    mem_addr_o         = '0;
    mem_wdata_o        = '0;
    unique case (state)
      IDLE: begin
        if (dcache_miss_req_i)
          state_next = LOOKUP;
      end
      LOOKUP: begin
        victim_addr_o = miss_addr;
        if (evict_valid && evict_dirty)
          state_next = WB;
        else if (!victim_hit_i)
          state_next = MEM_RD;
        else if (evict_valid)
          state_next = INSERT;
        else
          state_next = RESP;
      end
      WB: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = evict_addr;
        mem_wdata_o = evict_data;
        if (mem_ack_i)
          state_next = hit_q ? INSERT : MEM_RD;
      end
      MEM_RD: begin
        mem_req_o  = 1'b1;
        mem_addr_o = miss_addr;
        if (mem_ack_i)
          state_next = evict_valid ? INSERT : RESP;
      end
      INSERT: begin
        victim_wr_en_o   = 1'b1;
        victim_addr_o    = evict_addr;
        victim_wr_data_o = evict_data;
        state_next       = RESP;
      end
      RESP: begin
        dcache_miss_ack_o  = 1'b1;
        dcache_fill_data_o = fill_buf;
        dcache_fill_src_o  = hit_q;
        state_next         = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_victim_cache_ctrl.sv
// Directed bench for victim_cache_ctrl with a small victim cache model and a
// fixed-latency memory model; expected cycles and data are hand-computed.
module tb_victim_cache_ctrl;

  localparam int LW = 128;
  localparam int AW = 28;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush_i;
  logic          dcache_miss_req_i;
  logic [AW-1:0] dcache_miss_addr_i;
  logic          dcache_evict_valid_i;
  logic          dcache_evict_dirty_i;
  logic [AW-1:0] dcache_evict_addr_i;
  logic [LW-1:0] dcache_evict_data_i;
  logic          dcache_miss_ack_o;
  logic [LW-1:0] dcache_fill_data_o;
  logic          dcache_fill_src_o;
  logic          busy_o;
  logic [AW-1:0] victim_addr_o;
  logic [LW-1:0] victim_wr_data_o;
  logic          victim_wr_en_o;
  logic          victim_flush_o;
  logic          victim_hit_i;
  logic [LW-1:0] victim_rd_data_i;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [LW-1:0] mem_wdata_o;
  logic          mem_ack_i;
  logic [LW-1:0] mem_rdata_i;

  victim_cache_ctrl #(.DCACHE_LINE_WIDTH(LW), .VICTIM_ADDR_BITS(AW)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .dcache_miss_req_i(dcache_miss_req_i), .dcache_miss_addr_i(dcache_miss_addr_i),
    .dcache_evict_valid_i(dcache_evict_valid_i), .dcache_evict_dirty_i(dcache_evict_dirty_i),
    .dcache_evict_addr_i(dcache_evict_addr_i), .dcache_evict_data_i(dcache_evict_data_i),
    .dcache_miss_ack_o(dcache_miss_ack_o), .dcache_fill_data_o(dcache_fill_data_o),
    .dcache_fill_src_o(dcache_fill_src_o), .busy_o(busy_o),
    .victim_addr_o(victim_addr_o), .victim_wr_data_o(victim_wr_data_o),
    .victim_wr_en_o(victim_wr_en_o), .victim_flush_o(victim_flush_o),
    .victim_hit_i(victim_hit_i), .victim_rd_data_i(victim_rd_data_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  int check_count = 0;
  int pass_count  = 0;

  task automatic checkOutput(input string tag, input logic [LW-1:0] actual, input logic [LW-1:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  function automatic logic [LW-1:0] mem_line(input logic [AW-1:0] a);
    return {4{4'hC, a}};
  endfunction

  // Memory model: acks mem_lat cycles after mem_req_o rises.
  int            mem_lat = 3;
  int            mem_cnt = 0;
  int            wb_count = 0;
  int            rd_count = 0;
  logic [AW-1:0] wb_addr;
  logic [LW-1:0] wb_data;

  assign mem_ack_i   = mem_req_o && (mem_cnt == mem_lat);
  assign mem_rdata_i = mem_ack_i ? mem_line(mem_addr_o) : '0;

  always @(posedge clk) begin
    if (!mem_req_o || mem_ack_i) mem_cnt <= 0;
    else mem_cnt <= mem_cnt + 1;
    if (mem_req_o && mem_ack_i) begin
      if (mem_we_o) begin
        wb_count <= wb_count + 1;
        wb_addr  <= mem_addr_o;
        wb_data  <= mem_wdata_o;
      end else begin
        rd_count <= rd_count + 1;
      end
    end
  end

  // Victim cache model: four entries, round-robin replacement, in-place overwrite on tag match.
  logic [AW-1:0] v_addr [4];
  logic [LW-1:0] v_data [4];
  logic [3:0]    v_valid = '0;
  int            rr_ptr = 0;
  int            flush_count = 0;
  logic          pre_en = 1'b0;
  logic [AW-1:0] pre_addr;
  logic [LW-1:0] pre_data;

  always_comb begin
    victim_hit_i     = 1'b0;
    victim_rd_data_i = '0;
    if (!victim_wr_en_o)
      for (int i = 0; i < 4; i++)
        if (v_valid[i] && v_addr[i] == victim_addr_o) begin
          victim_hit_i     = 1'b1;
          victim_rd_data_i = v_data[i];
        end
  end

  always @(posedge clk) begin
    logic          wen;
    logic [AW-1:0] wa;
    logic [LW-1:0] wd;
    int            slot;
    wen  = pre_en || victim_wr_en_o;
    wa   = pre_en ? pre_addr : victim_addr_o;
    wd   = pre_en ? pre_data : victim_wr_data_o;
    slot = rr_ptr;
    if (wen) begin
      for (int i = 0; i < 4; i++)
        if (v_valid[i] && v_addr[i] == wa) slot = i;
      if (slot == rr_ptr) rr_ptr <= (rr_ptr + 1) % 4;
      v_addr[slot]  <= wa;
      v_data[slot]  <= wd;
      v_valid[slot] <= 1'b1;
    end
    if (victim_flush_o) begin
      v_valid     <= '0;
      flush_count <= flush_count + 1;
    end
  end

  task automatic preload(input logic [AW-1:0] a, input logic [LW-1:0] d);
    @(negedge clk);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  // Results of the most recent applyStimulus call, cycle numbers relative to the request cycle.
  int            ack_cycle, ins_cycle, mem_cycles;
  logic [AW-1:0] ins_addr, lookup_addr;
  logic          lookup_we, flush_in_req, fill_src;
  logic [LW-1:0] fill_data;

  task automatic applyStimulus(input logic [AW-1:0] addr, input logic ev_valid, input logic ev_dirty,
                               input logic [AW-1:0] ev_addr, input logic [LW-1:0] ev_data, input int flush_at);
    @(negedge clk);
    dcache_miss_req_i    = 1'b1;
    dcache_miss_addr_i   = addr;
    dcache_evict_valid_i = ev_valid;
    dcache_evict_dirty_i = ev_dirty;
    dcache_evict_addr_i  = ev_addr;
    dcache_evict_data_i  = ev_data;
    flush_i              = (flush_at == 0);
    #1 flush_in_req = victim_flush_o;
    ack_cycle = -1; ins_cycle = -1; mem_cycles = 0;
    ins_addr = '0; fill_data = '0; fill_src = 1'b0;
    for (int c = 1; c <= 60 && ack_cycle < 0; c++) begin
      @(negedge clk);
      dcache_miss_req_i = 1'b0;
      flush_i           = (c == flush_at);
      if (c == 1) begin
        lookup_addr = victim_addr_o;
        lookup_we   = victim_wr_en_o;
      end
      if (mem_req_o) mem_cycles++;
      if (victim_wr_en_o) begin
        ins_cycle = c;
        ins_addr  = victim_addr_o;
      end
      if (dcache_miss_ack_o) begin
        ack_cycle = c;
        fill_data = dcache_fill_data_o;
        fill_src  = dcache_fill_src_o;
      end
    end
    flush_i = 1'b0;
  endtask

  int wb0, rd0, fl0, acks;

  initial begin
    rst = 1'b0; flush_i = 1'b0; dcache_miss_req_i = 1'b0;
    dcache_miss_addr_i = '0; dcache_evict_valid_i = 1'b0; dcache_evict_dirty_i = 1'b0;
    dcache_evict_addr_i = '0; dcache_evict_data_i = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", busy_o, 0);
    checkOutput("reset_ack", dcache_miss_ack_o, 0);
    checkOutput("reset_mem_req", mem_req_o, 0);
    checkOutput("reset_vflush", victim_flush_o, 0);
    checkOutput("reset_vaddr", victim_addr_o, 0);
    rst = 1'b1;

    $display("[TB] hit, no evict");
    preload(28'h0000123, {LW/8{8'hAA}});
    applyStimulus(28'h0000123, 1'b0, 1'b0, '0, '0, -1);
    checkOutput("hit_lookup_addr", lookup_addr, 28'h0000123);
    checkOutput("hit_lookup_we", lookup_we, 0);
    checkOutput("hit_ack_cycle", ack_cycle, 2);
    checkOutput("hit_fill", fill_data, {LW/8{8'hAA}});
    checkOutput("hit_src", fill_src, 1);
    checkOutput("hit_mem_cycles", mem_cycles, 0);

    $display("[TB] miss, dirty evict, k=3");
    mem_lat = 3; wb0 = wb_count; rd0 = rd_count;
    applyStimulus(28'h0000456, 1'b1, 1'b1, 28'h0000789, {LW/8{8'h55}}, -1);
    checkOutput("mde_ack_cycle", ack_cycle, 11);
    checkOutput("mde_src", fill_src, 0);
    checkOutput("mde_fill", fill_data, mem_line(28'h0000456));
    checkOutput("mde_wb_count", wb_count - wb0, 1);
    checkOutput("mde_rd_count", rd_count - rd0, 1);
    checkOutput("mde_wb_addr", wb_addr, 28'h0000789);
    checkOutput("mde_wb_data", wb_data, {LW/8{8'h55}});
    checkOutput("mde_mem_cycles", mem_cycles, 8);
    checkOutput("mde_ins_cycle", ins_cycle, 10);
    checkOutput("mde_ins_addr", ins_addr, 28'h0000789);

    $display("[TB] hit with clean evict");
    applyStimulus(28'h0000789, 1'b1, 1'b0, 28'h0000ABC, {LW/8{8'h33}}, -1);
    checkOutput("hce_ins_cycle", ins_cycle, 2);
    checkOutput("hce_ins_addr", ins_addr, 28'h0000ABC);
    checkOutput("hce_ack_cycle", ack_cycle, 3);
    checkOutput("hce_src", fill_src, 1);
    checkOutput("hce_fill", fill_data, {LW/8{8'h55}});
    checkOutput("hce_mem_cycles", mem_cycles, 0);

    $display("[TB] flush during MEM_RD");
    fl0 = flush_count;
    applyStimulus(28'h0000999, 1'b0, 1'b0, '0, '0, 3);
    checkOutput("fmr_ack_cycle", ack_cycle, 6);
    checkOutput("fmr_fill", fill_data, mem_line(28'h0000999));
    checkOutput("fmr_no_early_flush", flush_count - fl0, 0);
    @(negedge clk);
    checkOutput("fmr_flush_pulse", victim_flush_o, 1);
    @(negedge clk);
    checkOutput("fmr_flush_drop", victim_flush_o, 0);
    checkOutput("fmr_flush_once", flush_count - fl0, 1);

    $display("[TB] flush with request in IDLE, k=0");
    mem_lat = 0; fl0 = flush_count;
    applyStimulus(28'h0000123, 1'b0, 1'b0, '0, '0, 0);
    checkOutput("sfr_req_cycle_flush", flush_in_req, 0);
    checkOutput("sfr_ack_cycle", ack_cycle, 3);
    checkOutput("sfr_src", fill_src, 0);
    checkOutput("sfr_fill", fill_data, mem_line(28'h0000123));
    checkOutput("sfr_no_early_flush", flush_count - fl0, 0);
    @(negedge clk);
    checkOutput("sfr_flush_pulse", victim_flush_o, 1);
    @(negedge clk);
    checkOutput("sfr_flush_drop", victim_flush_o, 0);

    $display("[TB] reset during write-back");
    mem_lat = 10; wb0 = wb_count;
    @(negedge clk);
    dcache_miss_req_i = 1'b1; dcache_miss_addr_i = 28'h0000500;
    dcache_evict_valid_i = 1'b1; dcache_evict_dirty_i = 1'b1;
    dcache_evict_addr_i = 28'h0000600; dcache_evict_data_i = {LW/8{8'h11}};
    @(negedge clk);
    dcache_miss_req_i = 1'b0;
    @(negedge clk);
    checkOutput("rwb_mem_req", mem_req_o, 1);
    checkOutput("rwb_mem_we", mem_we_o, 1);
    checkOutput("rwb_mem_addr", mem_addr_o, 28'h0000600);
    checkOutput("rwb_mem_wdata", mem_wdata_o, {LW/8{8'h11}});
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checkOutput("rwb_busy", busy_o, 0);
    checkOutput("rwb_mem_req_drop", mem_req_o, 0);
    checkOutput("rwb_mem_addr_zero", mem_addr_o, 0);
    checkOutput("rwb_mem_wdata_zero", mem_wdata_o, 0);
    checkOutput("rwb_ack", dcache_miss_ack_o, 0);
    checkOutput("rwb_vwr", victim_wr_en_o, 0);
    acks = 0;
    repeat (12) begin
      @(negedge clk);
      if (dcache_miss_ack_o || mem_req_o) acks++;
    end
    checkOutput("rwb_quiet_after", acks, 0);
    checkOutput("rwb_no_wb", wb_count - wb0, 0);
    preload(28'h0000321, {LW/8{8'h77}});
    applyStimulus(28'h0000321, 1'b0, 1'b0, '0, '0, -1);
    checkOutput("rwb_hit_ack_cycle", ack_cycle, 2);
    checkOutput("rwb_hit_fill", fill_data, {LW/8{8'h77}});
    checkOutput("rwb_hit_src", fill_src, 1);

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
